top_k_collector: RTL and testbench

Drain-side companion to the top-k compare-swap chain. It sits at the tail of a K-deep chain of top-k units and waits for the end-of-frame beat (TLAST) to leave the chain. It then snapshots every unit's held register value and streams the K results out over an AXI-stream master, largest first. Finally it issues a one-beat clear token (flag bit set) so the chain's held values are reset before the next frame.

---
 rtl/top_k_collector.sv | 208 ++++++++++++++++++++
 tb/tb_top_k_collector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/top_k_collector.sv
// ---------------------------------------------------------------------------
// top_k_collector
//
// Drain-side companion to a K-deep top-k compare-swap chain. It sinks beats
// from the chain tail. When the end-of-frame beat (TLAST) arrives, it
// snapshots every unit's held value and streams the K results out, largest
// first (unit 0 first). After the last result it emits a one-cycle clear
// token so the chain can reset its held values before the next frame.
//
// Parameters
//   INTEGER_SIZE : width W of one value (chain stream is W+1 bits, bit W = clear)
//   K            : number of chained units (>= 2)
//
// Ports
//   clk           in   clock, all logic on posedge
//   rst_n         in   asynchronous active-low reset
//   reg_TDATA     in   K*W  held value of unit i at [i*W +: W]
//   reg_TVALID    in   K    held-value valid of unit i
//   chain_TDATA   in   W+1  tail-unit data (discarded)
//   chain_TVALID  in   1    tail-unit valid
//   chain_TLAST   in   1    tail-unit last (end of frame)
//   chain_TREADY  out  1    ready to the chain tail (high only while idle)
//   out_TDATA     out  W    result value
//   out_TVALID    out  1    result valid
//   out_TLAST     out  1    marks the K-th result
//   out_TREADY    in   1    downstream ready
//   clear_TDATA   out  W+1  clear token {1'b1, W'b0} while clear_TVALID
//   clear_TVALID  out  1    clear token valid (one cycle, not handshaken)
// ---------------------------------------------------------------------------
module top_k_collector #(
    parameter int INTEGER_SIZE = 32,
    parameter int K            = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [K*INTEGER_SIZE-1:0]   reg_TDATA,
    input  logic [K-1:0]                reg_TVALID,
    input  logic [INTEGER_SIZE:0]       chain_TDATA,
    input  logic                        chain_TVALID,
    input  logic                        chain_TLAST,
    output logic                        chain_TREADY,
    output logic [INTEGER_SIZE-1:0]     out_TDATA,
    output logic                        out_TVALID,
    output logic                        out_TLAST,
    input  logic                        out_TREADY,
    output logic [INTEGER_SIZE:0]       clear_TDATA,
    output logic                        clear_TVALID
);

    localparam int W     = INTEGER_SIZE;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_idx_inc;

    logic [W-1:0]     r_snap [K];
    logic [K-1:0]     r_snap_vld;

    logic [W-1:0]     r_out_tdata;
    logic [W-1:0]     w_out_tdata_nxt;
    logic             r_out_tvalid;
    logic             w_out_tvalid_nxt;
    logic             r_out_tlast;
    logic             w_out_tlast_nxt;
    logic             r_clear_tvalid;
    logic             w_clear_tvalid_nxt;

    logic             w_capture;
    logic             w_out_hs;
    logic             w_at_last;

    // The tail data carries nothing the collector needs; only the
    // handshake and TLAST matter.
    logic             w_unused_chain;
    assign w_unused_chain = ^chain_TDATA;

    // chain_TREADY is the only combinational output: decoded from state.
    assign chain_TREADY = (r_state == S_IDLE);

    assign w_capture = (r_state == S_IDLE) && chain_TVALID && chain_TLAST;
    assign w_out_hs  = (r_state == S_SEND) && r_out_tvalid && out_TREADY;
    assign w_at_last = (r_idx == LAST_IDX);
    assign w_idx_inc = r_idx + 1'b1;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = '0;
                end
            end
            S_SEND: begin
                if (w_out_hs) begin
                    if (w_at_last) begin
                        w_state_nxt = S_CLEAR;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                    end
                end
            end
            S_CLEAR: begin
                // Clear token is fire-and-forget: exactly one cycle.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_out_tvalid_nxt   = (w_state_nxt == S_SEND);
        w_clear_tvalid_nxt = (w_state_nxt == S_CLEAR);
        w_out_tdata_nxt    = r_out_tdata;
        w_out_tlast_nxt    = r_out_tlast;

        if (w_capture) begin
            // The first result comes straight from the bus being captured,
            // so it is already on out_TDATA in the cycle after the capture.
            w_out_tdata_nxt = reg_TVALID[0] ? reg_TDATA[W-1:0] : '0;
            w_out_tlast_nxt = 1'b0;
        end else if (w_out_hs) begin
            if (w_at_last) begin
                w_out_tdata_nxt = '0;
                w_out_tlast_nxt = 1'b0;
            end else begin
                // Units whose held value is not valid report zero.
                w_out_tdata_nxt = r_snap_vld[w_idx_inc] ? r_snap[w_idx_inc] : '0;
                w_out_tlast_nxt = (w_idx_inc == LAST_IDX);
            end
        end
        // Without a handshake the current beat is held unchanged.
    end

    // -----------------------------------------------------------------------
    // Snapshot of the chain's held registers, taken on the TLAST edge
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) begin
                r_snap[i] <= '0;
            end
            r_snap_vld <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < K; i++) begin
                r_snap[i] <= reg_TDATA[i*W +: W];
            end
            r_snap_vld <= reg_TVALID;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_tdata    <= '0;
            r_out_tvalid   <= 1'b0;
            r_out_tlast    <= 1'b0;
            r_clear_tvalid <= 1'b0;
        end else begin
            r_out_tdata    <= w_out_tdata_nxt;
            r_out_tvalid   <= w_out_tvalid_nxt;
            r_out_tlast    <= w_out_tlast_nxt;
            r_clear_tvalid <= w_clear_tvalid_nxt;
        end
    end

    assign out_TDATA    = r_out_tdata;
    assign out_TVALID   = r_out_tvalid;
    assign out_TLAST    = r_out_tlast;
    assign clear_TVALID = r_clear_tvalid;
    assign clear_TDATA  = {r_clear_tvalid, {W{1'b0}}};

endmodule

// File: tb/tb_top_k_collector.sv
// ---------------------------------------------------------------------------
// tb_top_k_collector
//
// Directed bench for top_k_collector with K=4, W=32. Expected result beats
// are pushed to a queue when a frame is launched and popped when the DUT
// completes an output handshake. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_top_k_collector;

    localparam int W = 32;
    localparam int K = 4;

    logic             clk;
    logic             rst_n;
    logic [K*W-1:0]   reg_TDATA;
    logic [K-1:0]     reg_TVALID;
    logic [W:0]       chain_TDATA;
    logic             chain_TVALID;
    logic             chain_TLAST;
    logic             chain_TREADY;
    logic [W-1:0]     out_TDATA;
    logic             out_TVALID;
    logic             out_TLAST;
    logic             out_TREADY;
    logic [W:0]       clear_TDATA;
    logic             clear_TVALID;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [W:0] CLEAR_TOKEN = {1'b1, {W{1'b0}}};

    top_k_collector #(
        .INTEGER_SIZE (W),
        .K            (K)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_TDATA    (reg_TDATA),
        .reg_TVALID   (reg_TVALID),
        .chain_TDATA  (chain_TDATA),
        .chain_TVALID (chain_TVALID),
        .chain_TLAST  (chain_TLAST),
        .chain_TREADY (chain_TREADY),
        .out_TDATA    (out_TDATA),
        .out_TVALID   (out_TVALID),
        .out_TLAST    (out_TLAST),
        .out_TREADY   (out_TREADY),
        .clear_TDATA  (clear_TDATA),
        .clear_TVALID (clear_TVALID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [K*W-1:0] pack4(input logic [W-1:0] u0, input logic [W-1:0] u1,
                                             input logic [W-1:0] u2, input logic [W-1:0] u3);
        return {u3, u2, u1, u0};
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_out_valid"},   out_TVALID,   0);
        chk({tag, "_out_last"},    out_TLAST,    0);
        chk({tag, "_out_data"},    out_TDATA,    0);
        chk({tag, "_clear_valid"}, clear_TVALID, 0);
        chk({tag, "_clear_data"},  clear_TDATA,  0);
        chk({tag, "_chain_ready"}, chain_TREADY, 1);
    endtask

    // Called at a falling edge while idle. Presents a TLAST beat, pushes the
    // expected results, and returns at the falling edge of cycle t+1.
    task automatic start_frame(input logic [K*W-1:0] data, input logic [K-1:0] vld);
        exp_t e;
        chk("pre_capture_ready", chain_TREADY, 1);
        reg_TDATA    = data;
        reg_TVALID   = vld;
        chain_TDATA  = {1'b0, 32'($urandom)};
        chain_TVALID = 1'b1;
        chain_TLAST  = 1'b1;
        for (int i = 0; i < K; i++) begin
            e.d = vld[i] ? data[i*W +: W] : '0;
            e.l = (i == K - 1);
            sb.push_back(e);
        end
        @(negedge clk);
        chain_TVALID = 1'b0;
        chain_TLAST  = 1'b0;
    endtask

    // Entered at the falling edge of cycle t+1. Applies a ready pattern
    // (bit n used in the n-th SEND cycle, 1 afterwards), checks every
    // accepted beat against the queue, then the clear cycle and the return
    // of chain_TREADY.
    task automatic drain(input logic [15:0] rdy_pat, input int pat_len);
        int           n       = 0;
        bit           fin     = 0;
        bit           stalled = 0;
        logic [W-1:0] held_d  = '0;
        logic         held_l  = 1'b0;
        exp_t         e;
        while (!fin && n < 64) begin
            out_TREADY = (n < pat_len) ? rdy_pat[n] : 1'b1;
            chk("send_valid", out_TVALID, 1);
            chk("send_chain_ready", chain_TREADY, 0);
            chk("send_no_clear", clear_TVALID, 0);
            if (stalled) begin
                chk("stall_hold_data", out_TDATA, held_d);
                chk("stall_hold_last", out_TLAST, held_l);
            end
            if (out_TREADY) begin
                stalled = 0;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL sb_underflow observed=beat expected=none");
                    fin = 1;
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_TDATA, e.d);
                    chk("out_last", out_TLAST, e.l);
                    if (e.l) fin = 1;
                end
            end else begin
                stalled = 1;
                held_d  = out_TDATA;
                held_l  = out_TLAST;
            end
            n++;
            @(negedge clk);
        end
        if (!fin) begin
            vectors++;
            miscompares++;
            $error("FAIL drain_timeout observed=%0d cycles expected=last beat", n);
        end
        out_TREADY = 1'b1;
        chk("clear_valid", clear_TVALID, 1);
        chk("clear_data", clear_TDATA, CLEAR_TOKEN);
        chk("clear_out_valid", out_TVALID, 0);
        chk("clear_chain_ready", chain_TREADY, 0);
        @(negedge clk);
        chk("post_chain_ready", chain_TREADY, 1);
        chk("post_clear_valid", clear_TVALID, 0);
        chk("post_clear_data", clear_TDATA, 0);
        chk("post_out_valid", out_TVALID, 0);
    endtask

    initial begin
        exp_t e;
        rst_n        = 1'b0;
        reg_TDATA    = '0;
        reg_TVALID   = '0;
        chain_TDATA  = '0;
        chain_TVALID = 1'b0;
        chain_TLAST  = 1'b0;
        out_TREADY   = 1'b1;

        // Reset values, before any clock edge and after a few edges.
        #1;
        check_idle_outputs("reset_t0");
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // Basic frame, ready always high.
        start_frame(pack4(32'd77, 32'd20, 32'd9, 32'd5), 4'b1111);
        drain(16'h0000, 0);

        // Backpressure: ready 1,0,0,1,0,1,1.
        start_frame(pack4(32'd77, 32'd20, 32'd9, 32'd5), 4'b1111);
        drain(16'b110_1001, 7);

        // Partial fill: invalid units report zero even with data present.
        start_frame(pack4(32'd40, 32'd12, 32'd99, 32'd123), 4'b0011);
        drain(16'h0000, 0);

        // Snapshot isolation: bus changes and a TLAST pulse during SEND.
        start_frame(pack4(32'd77, 32'd20, 32'd9, 32'd5), 4'b1111);
        reg_TDATA    = '1;
        chain_TVALID = 1'b1;
        chain_TLAST  = 1'b1;
        drain(16'h0000, 0);
        chain_TVALID = 1'b0;
        chain_TLAST  = 1'b0;
        reg_TDATA    = '0;
        repeat (3) begin
            @(negedge clk);
            chk("iso_no_second_frame", out_TVALID, 0);
        end
        chk("iso_sb_empty", sb.size(), 0);

        // Non-last traffic is sunk.
        for (int i = 0; i < 10; i++) begin
            chain_TVALID = 1'b1;
            chain_TLAST  = 1'b0;
            chain_TDATA  = {1'b0, 32'($urandom)};
            @(negedge clk);
            chk("nonlast_out_valid", out_TVALID, 0);
            chk("nonlast_chain_ready", chain_TREADY, 1);
        end
        chain_TVALID = 1'b0;

        // Reset after the second result beat.
        start_frame(pack4(32'd500, 32'd400, 32'd300, 32'd200), 4'b1111);
        out_TREADY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            chk("rst_pre_data", out_TDATA, e.d);
            chk("rst_pre_valid", out_TVALID, 1);
            @(negedge clk);
        end
        sb.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clk);
        check_idle_outputs("reset_mid_held");
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_idle_outputs("post_reset_idle");
        end

        // Fresh frame after the aborted one starts at index 0.
        start_frame(pack4(32'd1000, 32'd300, 32'd2, 32'd1), 4'b1111);
        drain(16'b0_0101, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
